// File: rtl/reqgnt_monitor.sv
// Passive multi-channel req/gnt protocol monitor: per-channel in-order age queue with sticky error flags.
// Optional REQGNT_MONITOR_STATS_EN adds per-channel grant totals and worst observed grant latency.
module reqgnt_monitor #(
    parameter  int N_CH    = 4,
    parameter  int MAX_OUT = 8,
    parameter  int MIN_LAT = 2,
    parameter  int MAX_LAT = 8,
    localparam int CW      = $clog2(MAX_OUT + 1),
    localparam int LW      = $clog2(MAX_LAT + 2)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_err,
    input  logic [N_CH-1:0]    req,
    input  logic [N_CH-1:0]    gnt,
    output logic [N_CH*CW-1:0] outstanding,
`ifdef REQGNT_MONITOR_STATS_EN
    output logic [N_CH*16-1:0] grant_total,
    output logic [N_CH*LW-1:0] max_lat_seen,
`endif
    output logic [N_CH-1:0]    err_underflow,
    output logic [N_CH-1:0]    err_overflow,
    output logic [N_CH-1:0]    err_early,
    output logic [N_CH-1:0]    err_timeout,
    output logic               err_any
);

    localparam int          PW       = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam logic [LW-1:0] AGE_SAT = LW'(MAX_LAT + 1);

    // Pointers wrap explicitly so MAX_OUT need not be a power of two.
    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic [LW-1:0] r_age [MAX_OUT];
        logic [PW-1:0] r_head;
        logic [PW-1:0] r_tail;
        logic [CW-1:0] r_count;
        logic          r_udf, r_ovf, r_early, r_tmo;

        logic          w_empty, w_full, w_pop, w_push;
        logic [LW-1:0] w_head_age;
        logic          w_ev_udf, w_ev_ovf, w_ev_early, w_ev_tmo;

        assign w_empty    = (r_count == '0);
        assign w_full     = (r_count == CW'(MAX_OUT));
        assign w_head_age = r_age[r_head];
        // A same-cycle req is never eligible for the grant: pop only sees prior entries.
        assign w_pop      = gnt[gi] && !w_empty;
        assign w_push     = req[gi] && (!w_full || w_pop);

        assign w_ev_udf   = gnt[gi] && w_empty;
        assign w_ev_ovf   = req[gi] && w_full && !gnt[gi];
        assign w_ev_early = w_pop && (w_head_age < LW'(MIN_LAT));
        assign w_ev_tmo   = !w_empty && !gnt[gi] && (w_head_age == LW'(MAX_LAT));

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int e = 0; e < MAX_OUT; e++) begin
                    r_age[e] <= '0;
                end
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
                r_udf   <= 1'b0;
                r_ovf   <= 1'b0;
                r_early <= 1'b0;
                r_tmo   <= 1'b0;
            end else begin
                // Ages of empty slots are don't-care; they are overwritten on push.
                for (int e = 0; e < MAX_OUT; e++) begin
                    if (r_age[e] != AGE_SAT) begin
                        r_age[e] <= r_age[e] + 1'b1;
                    end
                end
                if (w_push) begin
                    r_age[r_tail] <= LW'(1);
                    r_tail        <= f_next(r_tail);
                end
                if (w_pop) begin
                    r_head <= f_next(r_head);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + 1'b1;
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - 1'b1;
                end
                r_udf   <= w_ev_udf   | (r_udf   & ~clr_err);
                r_ovf   <= w_ev_ovf   | (r_ovf   & ~clr_err);
                r_early <= w_ev_early | (r_early & ~clr_err);
                r_tmo   <= w_ev_tmo   | (r_tmo   & ~clr_err);
            end
        end

        assign outstanding[gi*CW +: CW] = r_count;
        assign err_underflow[gi]        = r_udf;
        assign err_overflow[gi]         = r_ovf;
        assign err_early[gi]            = r_early;
        assign err_timeout[gi]          = r_tmo;

`ifdef REQGNT_MONITOR_STATS_EN
        logic [15:0]   r_gtot;
        logic [LW-1:0] r_maxlat;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_gtot   <= '0;
                r_maxlat <= '0;
            end else if (w_pop) begin
                // A pop in the clearing cycle restarts the statistics from this grant.
                if (clr_err) begin
                    r_gtot   <= 16'd1;
                    r_maxlat <= w_head_age;
                end else begin
                    if (r_gtot != 16'hFFFF) begin
                        r_gtot <= r_gtot + 1'b1;
                    end
                    if (w_head_age > r_maxlat) begin
                        r_maxlat <= w_head_age;
                    end
                end
            end else if (clr_err) begin
                r_gtot   <= '0;
                r_maxlat <= '0;
            end
        end

        assign grant_total[gi*16 +: 16]  = r_gtot;
        assign max_lat_seen[gi*LW +: LW] = r_maxlat;
`endif
    end

    assign err_any = |{err_underflow, err_overflow, err_early, err_timeout};

endmodule

// File: tb/tb_reqgnt_monitor.sv
// Randomized scoreboard bench for reqgnt_monitor: a queue-of-issue-cycles model predicts each edge's outputs.
module tb_reqgnt_monitor;

    localparam int N  = 4;
    localparam int MO = 8;
    localparam int MN = 2;
    localparam int MX = 8;
    localparam int CW = 4;
    localparam int LW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            clr_err;
    logic [N-1:0]    req;
    logic [N-1:0]    gnt;
    logic [N*CW-1:0] outstanding;
    logic [N-1:0]    err_underflow, err_overflow, err_early, err_timeout;
    logic            err_any;
`ifdef REQGNT_MONITOR_STATS_EN
    logic [N*16-1:0] grant_total;
    logic [N*LW-1:0] max_lat_seen;
`endif

    always #5 clk = ~clk;

    reqgnt_monitor #(
        .N_CH    (N),
        .MAX_OUT (MO),
        .MIN_LAT (MN),
        .MAX_LAT (MX)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clr_err       (clr_err),
        .req           (req),
        .gnt           (gnt),
        .outstanding   (outstanding),
`ifdef REQGNT_MONITOR_STATS_EN
        .grant_total   (grant_total),
        .max_lat_seen  (max_lat_seen),
`endif
        .err_underflow (err_underflow),
        .err_overflow  (err_overflow),
        .err_early     (err_early),
        .err_timeout   (err_timeout),
        .err_any       (err_any)
    );

    typedef struct packed {
        logic [N*CW-1:0] outst;
        logic [N-1:0]    udf;
        logic [N-1:0]    ovf;
        logic [N-1:0]    early;
        logic [N-1:0]    tmo;
        logic            any;
    } exp_t;

    exp_t         sb[$];
    int           q[N][$];          // issue cycle of each outstanding request, oldest first
    logic [N-1:0] m_udf, m_ovf, m_early, m_tmo;
    int           cyc   = 0;
    int           n_cmp = 0;
    int           n_bad = 0;
    int           p_req[5] = '{30, 70, 20, 40, 50};
    int           p_gnt[5] = '{30, 10,  2, 80, 50};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Drive one cycle of stimulus and queue the outputs expected after its closing edge.
    task automatic step(input logic r, input logic cl, input logic [N-1:0] rq, input logic [N-1:0] gn);
        exp_t e;
        int   sz;
        int   age;
        logic pop;
        @(negedge clk);
        rst     = r;
        clr_err = cl;
        req     = rq;
        gnt     = gn;
        e = '0;
        for (int ch = 0; ch < N; ch++) begin
            if (r) begin
                q[ch].delete();
                m_udf[ch]   = 1'b0;
                m_ovf[ch]   = 1'b0;
                m_early[ch] = 1'b0;
                m_tmo[ch]   = 1'b0;
            end else begin
                sz  = q[ch].size();
                age = (sz > 0) ? cyc - q[ch][0] : 0;
                pop = gn[ch] && (sz > 0);
                m_udf[ch]   = (gn[ch] && sz == 0)             | (m_udf[ch]   & !cl);
                m_ovf[ch]   = (rq[ch] && sz == MO && !gn[ch]) | (m_ovf[ch]   & !cl);
                m_early[ch] = (pop && age < MN)               | (m_early[ch] & !cl);
                m_tmo[ch]   = (sz > 0 && !gn[ch] && age == MX) | (m_tmo[ch]  & !cl);
                if (pop) void'(q[ch].pop_front());
                if (rq[ch] && (sz < MO || pop)) q[ch].push_back(cyc);
            end
            e.outst[ch*CW +: CW] = CW'(q[ch].size());
        end
        e.udf   = m_udf;
        e.ovf   = m_ovf;
        e.early = m_early;
        e.tmo   = m_tmo;
        e.any   = |{m_udf, m_ovf, m_early, m_tmo};
        sb.push_back(e);
        $display("cyc %0d rst=%b clr=%b req=%h gnt=%h -> outst=%h udf=%h ovf=%h early=%h tmo=%h",
                 cyc, r, cl, rq, gn, e.outst, e.udf, e.ovf, e.early, e.tmo);
        cyc++;
    endtask

    // Monitor: compares DUT outputs against the scoreboard just after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("outstanding",   32'(outstanding),   32'(e.outst));
                chk("err_underflow", 32'(err_underflow), 32'(e.udf));
                chk("err_overflow",  32'(err_overflow),  32'(e.ovf));
                chk("err_early",     32'(err_early),     32'(e.early));
                chk("err_timeout",   32'(err_timeout),   32'(e.tmo));
                chk("err_any",       32'(err_any),       32'(e.any));
            end
        end
    end

    initial begin
        logic [N-1:0] rq;
        logic [N-1:0] gn;
        logic         cl;
        logic         r;
        rst     = 1'b1;
        clr_err = 1'b0;
        req     = '0;
        gnt     = '0;
        m_udf   = '0;
        m_ovf   = '0;
        m_early = '0;
        m_tmo   = '0;

        step(1'b1, 1'b0, '0, '0);
        step(1'b1, 1'b0, '0, '0);
        // Simultaneous req+gnt on empty queues, then reset mid-operation.
        step(1'b0, 1'b0, '1, '1);
        step(1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, '0, '0);
        step(1'b0, 1'b0, '0, '0);

        for (int ph = 0; ph < 5; ph++) begin
            for (int i = 0; i < 300; i++) begin
                for (int ch = 0; ch < N; ch++) begin
                    rq[ch] = ($urandom_range(99) < p_req[ph]);
                    gn[ch] = ($urandom_range(99) < p_gnt[ph]);
                end
                cl = ($urandom_range(99) < 3);
                r  = (ph == 4) && ($urandom_range(149) == 0);
                step(r, cl, rq, gn);
            end
        end
        step(1'b0, 1'b0, '0, '0);

        @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
